// File: rtl/qr_acc_pkg.sv
// Shared types, default widths and the saturation helper for the QR
// bit-serial accumulator slice.
package qr_acc_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} bsacc_state_t;

  localparam int unsigned QR_NUM_COLS     = 8;
  localparam int unsigned QR_NUM_ADC_BITS = 4;
  localparam int unsigned QR_NUM_ACC_BITS = 12;
  localparam int unsigned QR_NUM_CFG_BITS = 8;
  localparam int unsigned QR_MAX_IN_BITS  = 8;
  localparam int unsigned QR_ADC_LATENCY  = 1;

  // Returns {above_max, below_min} of v against the signed 'bits'-wide range.
  function automatic logic [1:0] sat_dir(input logic signed [31:0] v,
                                         input int unsigned bits);
    logic signed [31:0] lim;
    lim = 32'sd1 <<< (bits - 1);
    return {v > (lim - 32'sd1), v < -lim};
  endfunction

endpackage

// File: rtl/qr_shift_acc.sv
// One column of the bit-serial shift-accumulator: acc = 2*acc + adc,
// with the first plane optionally negated and the result saturated.
module qr_shift_acc
  import qr_acc_pkg::*;
#(
  parameter int unsigned numAdcBits = QR_NUM_ADC_BITS,
  parameter int unsigned numAccBits = QR_NUM_ACC_BITS
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clr,
  input  logic                  first,
  input  logic                  valid,
  input  logic                  signed_mode,
  input  logic [numAdcBits-1:0] adc,
  output logic [numAccBits-1:0] acc,
  output logic                  sat
);

  localparam int unsigned EW = numAccBits + 2;

  logic signed [EW-1:0] adc_ext;
  logic signed [EW-1:0] acc_ext;
  logic signed [EW-1:0] sum;
  logic [1:0]            dir;
  logic [numAccBits-1:0] acc_nxt;

  // Extended width keeps -(-2^(numAdcBits-1)) and 2*acc+adc exact before clipping.
  always_comb begin
    adc_ext = EW'($signed(adc));
    acc_ext = EW'($signed(acc));
    if (first) sum = signed_mode ? -adc_ext : adc_ext;
    else       sum = (acc_ext <<< 1) + adc_ext;
    dir = sat_dir(32'(sum), numAccBits);
    if (dir[1])      acc_nxt = {1'b0, {(numAccBits-1){1'b1}}};
    else if (dir[0]) acc_nxt = {1'b1, {(numAccBits-1){1'b0}}};
    else             acc_nxt = sum[numAccBits-1:0];
  end

  always_ff @(posedge clk) begin
    if (!nrst || clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (valid) begin
      acc <= acc_nxt;
      sat <= sat | (|dir);
    end
  end

endmodule

// File: rtl/qr_bitserial_accum.sv
// Sequences MSB-first bit-plane MACs to the analog QR wrapper and shift-
// accumulates each column's ADC code into a saturated signed result.
module qr_bitserial_accum
  import qr_acc_pkg::*;
#(
  parameter int unsigned numCols    = QR_NUM_COLS,
  parameter int unsigned numAdcBits = QR_NUM_ADC_BITS,
  parameter int unsigned numAccBits = QR_NUM_ACC_BITS,
  parameter int unsigned numCfgBits = QR_NUM_CFG_BITS,
  parameter int unsigned maxInBits  = QR_MAX_IN_BITS,
  parameter int unsigned adcLatency = QR_ADC_LATENCY
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic [numCfgBits-1:0]            n_input_bits_cfg,
  input  logic                             signed_cfg,
  input  logic                             start_i,
  output logic                             start_ready_o,
  output logic                             mac_en_o,
  output logic [$clog2(maxInBits)-1:0]     bit_idx_o,
  input  logic [numCols*numAdcBits-1:0]    adc_in_i,
  output logic [numCols*numAccBits-1:0]    acc_o,
  output logic [numCols-1:0]               sat_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i
);

  localparam int unsigned IDXW = $clog2(maxInBits);

  bsacc_state_t          state, state_nxt;
  logic [IDXW-1:0]       idx;
  logic [numCfgBits-1:0] n_res;
  logic                  signed_lat;
  logic                  first_pend;
  logic                  accept;
  logic                  sample_vld;
  logic                  pending;

  assign accept = (state == IDLE) && start_i;

  always_comb begin
    if (n_input_bits_cfg == '0)
      n_res = numCfgBits'(1);
    else if (n_input_bits_cfg > numCfgBits'(maxInBits))
      n_res = numCfgBits'(maxInBits);
    else
      n_res = n_input_bits_cfg;
  end

  // Sample qualification follows mac_en_o through a fixed-depth delay line.
  if (adcLatency == 0) begin : g_nolat
    assign sample_vld = mac_en_o;
    assign pending    = 1'b0;
  end else begin : g_lat
    localparam logic [adcLatency-1:0] TOP = adcLatency'(1) << (adcLatency - 1);
    logic [adcLatency-1:0] mac_dly;
    always_ff @(posedge clk) begin
      if (!nrst) mac_dly <= '0;
      else       mac_dly <= (mac_dly << 1) | adcLatency'(mac_en_o);
    end
    assign sample_vld = |(mac_dly & TOP);
    assign pending    = |(mac_dly & ~TOP);
  end

  always_ff @(posedge clk) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    start_ready_o = 1'b0;
    mac_en_o      = 1'b0;
    out_valid_o   = 1'b0;
    bit_idx_o     = '0;
    case (state)
      IDLE: begin
        start_ready_o = 1'b1;
        if (start_i) state_nxt = ISSUE;
      end
      ISSUE: begin
        mac_en_o  = 1'b1;
        bit_idx_o = idx;
        if (idx == '0) state_nxt = (adcLatency == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (!pending) state_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      idx        <= '0;
      signed_lat <= 1'b0;
      first_pend <= 1'b0;
    end else if (accept) begin
      idx        <= IDXW'(n_res - numCfgBits'(1));
      signed_lat <= signed_cfg;
      first_pend <= 1'b1;
    end else begin
      if (state == ISSUE && idx != '0) idx <= idx - IDXW'(1);
      if (sample_vld) first_pend <= 1'b0;
    end
  end

  for (genvar g = 0; g < numCols; g++) begin : g_col
    qr_shift_acc #(
      .numAdcBits(numAdcBits),
      .numAccBits(numAccBits)
    ) u_col (
      .clk        (clk),
      .nrst       (nrst),
      .clr        (accept),
      .first      (first_pend),
      .valid      (sample_vld),
      .signed_mode(signed_lat),
      .adc        (adc_in_i[g*numAdcBits +: numAdcBits]),
      .acc        (acc_o[g*numAccBits +: numAccBits]),
      .sat        (sat_o[g])
    );
  end

endmodule
